// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : if_wb
// Brief    : 32-bit Wishbone classic bus bundle with master and slave views.
// Revision : 1.0
// ============================================================================
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;

    modport slave (
        input  cyc, stb, we, sel, adr, dat_i,
        output dat_o, ack
    );

    modport master (
        output cyc, stb, we, sel, adr, dat_i,
        input  dat_o, ack
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Brief    : SPI mode-0 byte slave with Wishbone register access and IRQ.
// Revision : 1.0
// ============================================================================
module spi_slave #(
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic interrupt
);
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic        r_sclk_d, r_ss_d;
    logic [1:0]  r_flush;
    logic        r_armed;

    logic [2:0]  r_bitcnt;
    logic [7:0]  r_rx_sh, r_rx_data, r_tx_sh, r_tx_hold;
    logic        r_rx_full, r_tx_full, r_ovf, r_udr, r_udr_pend;
    logic [2:0]  r_ctrl;
    logic        r_irq;
    logic        r_ack, r_done;
    logic [31:0] r_dat_o;

    logic        w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
    logic        w_rx_edge, w_tx_edge, w_entry_load, w_bound_load, w_load, w_shift;
    logic        w_byte_done;
    logic [7:0]  w_rx_byte;
    logic        w_req, w_start, w_rd_data, w_wr_data, w_wr_stat, w_wr_ctrl;
    logic [31:0] w_rdata;
    logic        w_busy;
    logic        w_unused;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sclk_sync <= 2'b00;
            r_ss_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
            r_flush     <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_ss_sync   <= {r_ss_sync[0], ss_n};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_sclk_d    <= r_sclk_sync[1];
            r_ss_d      <= r_ss_sync[1];
            r_flush     <= {r_flush[0], 1'b1};
            // Only a select seen high after the synchronizer has flushed arms a new frame.
            if (r_flush[1] && r_ss_sync[1]) r_armed <= 1'b1;
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
    assign w_ss_fall   = ~r_ss_sync[1] & r_ss_d & r_armed;
    assign w_ss_rise   = r_ss_sync[1] & ~r_ss_d;
    assign w_rx_byte   = {r_rx_sh[6:0], r_mosi_sync[1]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rx_edge    = 1'b0;
        w_tx_edge    = 1'b0;
        w_entry_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt  = S_ACTIVE;
                    w_entry_load = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_ss_rise) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_rx_edge = w_sclk_rise;
                    w_tx_edge = w_sclk_fall;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_busy       = (r_state == S_ACTIVE);
    assign w_bound_load = w_tx_edge & (r_bitcnt == 3'd0);
    assign w_load       = w_entry_load | w_bound_load;
    assign w_shift      = w_tx_edge & ~w_bound_load;
    assign w_byte_done  = w_rx_edge & (r_bitcnt == 3'd7);

    assign w_req     = bus.cyc & bus.stb;
    assign w_start   = w_req & ~r_ack & ~r_done;
    assign w_rd_data = w_start & ~bus.we & (bus.adr[3:2] == 2'd0);
    assign w_wr_data = w_start & bus.we & bus.sel[0] & (bus.adr[3:2] == 2'd0);
    assign w_wr_stat = w_start & bus.we & bus.sel[0] & (bus.adr[3:2] == 2'd1);
    assign w_wr_ctrl = w_start & bus.we & bus.sel[0] & (bus.adr[3:2] == 2'd2);
    assign w_unused  = ^{bus.adr[31:4], bus.adr[1:0], bus.sel[3:1], bus.dat_i[31:8]};

    always_comb begin
        w_rdata = 32'd0;
        case (bus.adr[3:2])
            2'd0:    w_rdata = {24'd0, r_rx_data};
            2'd1:    w_rdata = {27'd0, w_busy, r_udr, r_ovf, r_tx_full, r_rx_full};
            2'd2:    w_rdata = {29'd0, r_ctrl};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack   <= 1'b0;
            r_done  <= 1'b0;
            r_dat_o <= 32'd0;
        end else begin
            r_ack  <= w_start;
            r_done <= w_req & (r_done | r_ack);
            if (w_start) r_dat_o <= w_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bitcnt  <= 3'd0;
            r_rx_sh   <= 8'd0;
            r_rx_data <= 8'd0;
            r_rx_full <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_ss_rise) begin
                r_bitcnt <= 3'd0;
                r_rx_sh  <= 8'd0;
            end else if (w_rx_edge) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_rx_sh  <= w_rx_byte;
            end
            if (w_rd_data) r_rx_full <= 1'b0;
            if (w_wr_stat && bus.dat_i[2]) r_ovf <= 1'b0;
            // A read acked this cycle has already captured the old byte, so the new one fits.
            if (w_byte_done) begin
                if (!r_rx_full || w_rd_data) begin
                    r_rx_data <= w_rx_byte;
                    r_rx_full <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_tx_sh    <= 8'd0;
            r_tx_hold  <= 8'd0;
            r_tx_full  <= 1'b0;
            r_udr      <= 1'b0;
            r_udr_pend <= 1'b0;
        end else begin
            if (w_wr_stat && bus.dat_i[3]) r_udr <= 1'b0;
            if (w_load) begin
                r_tx_sh   <= r_tx_full ? r_tx_hold : IDLE_BYTE;
                r_tx_full <= 1'b0;
                // An empty end-of-byte load only counts once the master clocks into it.
                if (!r_tx_full) begin
                    if (w_entry_load) r_udr      <= 1'b1;
                    else              r_udr_pend <= 1'b1;
                end
            end else if (w_shift) begin
                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end
            if (w_rx_edge && r_udr_pend) begin
                r_udr      <= 1'b1;
                r_udr_pend <= 1'b0;
            end
            if (w_ss_rise) r_udr_pend <= 1'b0;
            if (w_wr_data) begin
                r_tx_hold <= bus.dat_i[7:0];
                r_tx_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ctrl <= 3'd0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= bus.dat_i[2:0];
            r_irq <= (r_ctrl[0] & r_rx_full) | (r_ctrl[1] & ~r_tx_full)
                   | (r_ctrl[2] & (r_ovf | r_udr));
        end
    end

    assign bus.ack   = r_ack;
    assign bus.dat_o = r_dat_o;
    assign miso      = r_tx_sh[7];
    assign miso_oe   = ~r_ss_sync[1];
    assign interrupt = r_irq;

endmodule
`default_nettype wire
